// File: rtl/ibex_prefetch_req_ctrl_pkg.sv
// Shared helpers for the instruction-fetch request path.
package ibex_prefetch_req_ctrl_pkg;

    localparam logic [31:0] FETCH_STRIDE = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_prefetch_outstanding_tracker.sv
// Counts granted-but-unanswered fetches and carries a per-request discard flag, oldest at index 0.
// A branch marks every request already in flight as stale.
module ibex_prefetch_outstanding_tracker #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic gnt_i,
    input  logic rvalid_i,
    input  logic branch_i,
    input  logic new_discard_i,
    output logic full_o,
    output logic empty_o,
    output logic oldest_discard_o
);
    import ibex_prefetch_req_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_tmp;
    logic [NUM_REQS-1:0] disc_q, disc_d;
    logic                pop;

    assign empty_o          = (cnt_q == '0);
    assign full_o           = (cnt_q == CNT_W'(NUM_REQS));
    assign oldest_discard_o = disc_q[0];
    assign pop              = rvalid_i & ~empty_o;

    // Retire first, then flag stale entries, then append: the new entry's flag
    // must survive the branch-wide set when it was issued to the target.
    always_comb begin
        disc_d  = disc_q;
        cnt_tmp = cnt_q;
        if (pop) begin
            disc_d  = disc_q >> 1;
            cnt_tmp = cnt_q - CNT_W'(1);
        end
        if (branch_i) begin
            disc_d = '1;
        end
        cnt_d = cnt_tmp;
        if (gnt_i) begin
            for (int i = 0; i < int'(NUM_REQS); i++) begin
                if (CNT_W'(i) == cnt_tmp) begin
                    disc_d[i] = new_discard_i;
                end
            end
            cnt_d = cnt_tmp + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            disc_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            disc_q <= disc_d;
        end
    end

    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_i |-> !empty_o);
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= CNT_W'(NUM_REQS));

endmodule

// File: rtl/ibex_prefetch_req_ctrl.sv
// Fetch request controller in front of the fetch FIFO: issues word fetches, tracks
// outstanding requests, and drops responses made stale by a branch.
module ibex_prefetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);
    import ibex_prefetch_req_ctrl_pkg::*;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } req_state_e;

    req_state_e  state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] held_addr_q, held_addr_d;
    logic        held_disc_q, held_disc_d;
    logic [31:0] branch_addr_q, branch_addr_d;
    logic        branch_pend_q, branch_pend_d;
    logic        idle_issue, gnt_fire, new_discard;
    logic        trk_full, trk_empty, oldest_disc;

    always_comb begin
        state_d      = state_q;
        held_addr_d  = held_addr_q;
        held_disc_d  = held_disc_q;
        idle_issue   = 1'b0;
        instr_req_o  = 1'b0;
        instr_addr_o = fetch_addr_q;
        new_discard  = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_issue = req_i & ~rst_i & (fifo_ready_i | branch_i) & ~trk_full;
                instr_req_o = idle_issue;
                if (branch_i) begin
                    instr_addr_o = word_align(addr_i);
                end else if (branch_pend_q) begin
                    instr_addr_o = branch_addr_q;
                end
                if (idle_issue && !instr_gnt_i) begin
                    state_d     = WAIT_GNT;
                    held_addr_d = instr_addr_o;
                    held_disc_d = 1'b0;
                end
            end
            WAIT_GNT: begin
                // Bus protocol forbids withdrawing a request, so a branch only marks it stale.
                instr_req_o  = 1'b1;
                instr_addr_o = held_addr_q;
                new_discard  = held_disc_q | branch_i;
                if (branch_i) begin
                    held_disc_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    state_d     = IDLE;
                    held_disc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_fire     = instr_req_o & instr_gnt_i;
    assign fetch_addr_d = gnt_fire ? instr_addr_o + FETCH_STRIDE : fetch_addr_q;

    always_comb begin
        branch_pend_d = branch_pend_q;
        branch_addr_d = branch_addr_q;
        if (branch_i && !idle_issue) begin
            branch_pend_d = 1'b1;
            branch_addr_d = word_align(addr_i);
        end else if (idle_issue) begin
            branch_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            held_addr_q   <= '0;
            held_disc_q   <= 1'b0;
            branch_addr_q <= '0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            held_addr_q   <= held_addr_d;
            held_disc_q   <= held_disc_d;
            branch_addr_q <= branch_addr_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    ibex_prefetch_outstanding_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_tracker (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .gnt_i            (gnt_fire),
        .rvalid_i         (instr_rvalid_i),
        .branch_i         (branch_i),
        .new_discard_i    (new_discard),
        .full_o           (trk_full),
        .empty_o          (trk_empty),
        .oldest_discard_o (oldest_disc)
    );

    assign fifo_valid_o = instr_rvalid_i & ~trk_empty & ~oldest_disc & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign busy_o       = instr_req_o | ~trk_empty;

    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (instr_req_o && !instr_gnt_i) |=> (instr_addr_o == $past(instr_addr_o)));

endmodule

// File: tb/tb_ibex_prefetch_req_ctrl.sv
// Directed bench: each cycle drives inputs 1ns after the rising edge and checks
// outputs 4ns later, against hand-derived expectations.
module tb_ibex_prefetch_req_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        branch;
    logic [31:0] addr;
    logic        busy;
    logic        fifo_clear;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] fifo_addr;
    logic [31:0] fifo_rdata;
    logic        fifo_err;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    int n_checks = 0;
    int n_errors = 0;

    ibex_prefetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .branch_i       (branch),
        .addr_i         (addr),
        .busy_o         (busy),
        .fifo_clear_o   (fifo_clear),
        .fifo_valid_o   (fifo_valid),
        .fifo_ready_i   (fifo_ready),
        .fifo_addr_o    (fifo_addr),
        .fifo_rdata_o   (fifo_rdata),
        .fifo_err_o     (fifo_err),
        .instr_req_o    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_addr_o   (instr_addr),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .instr_err_i    (instr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #4;
    endtask

    task automatic clear_inputs();
        req          = 1'b0;
        branch       = 1'b0;
        addr         = '0;
        fifo_ready   = 1'b1;
        instr_gnt    = 1'b0;
        instr_rvalid = 1'b0;
        instr_rdata  = '0;
        instr_err    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();

        // 1: streaming fetch after a branch to 0x100, one response per cycle
        do_reset();
        probe();
        check_eq("rst_req", instr_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", fifo_valid, 0);
        check_eq("rst_clear", fifo_clear, 0);
        tick();
        req = 1; branch = 1; addr = 32'h100; instr_gnt = 1;
        probe();
        check_eq("t1_addr0", instr_addr, 32'h100);
        check_eq("t1_req0", instr_req, 1);
        check_eq("t1_clear", fifo_clear, 1);
        tick();
        branch = 0; instr_rvalid = 1; instr_rdata = 32'hA0;
        probe();
        check_eq("t1_addr1", instr_addr, 32'h104);
        check_eq("t1_valid1", fifo_valid, 1);
        check_eq("t1_rdata1", fifo_rdata, 32'hA0);
        tick();
        instr_rdata = 32'hA1;
        probe();
        check_eq("t1_addr2", instr_addr, 32'h108);
        check_eq("t1_valid2", fifo_valid, 1);
        tick();
        req = 0; instr_gnt = 0; instr_rdata = 32'hA2;
        probe();
        check_eq("t1_req_off", instr_req, 0);
        check_eq("t1_valid3", fifo_valid, 1);
        check_eq("t1_busy3", busy, 1);
        tick();
        instr_rvalid = 0;
        probe();
        check_eq("t1_idle_busy", busy, 0);

        // 2: responses withheld, only NUM_REQS grants go out
        do_reset();
        req = 1; branch = 1; addr = 32'h100; instr_gnt = 1;
        probe();
        check_eq("t2_addr0", instr_addr, 32'h100);
        tick();
        branch = 0;
        probe();
        check_eq("t2_addr1", instr_addr, 32'h104);
        check_eq("t2_req1", instr_req, 1);
        tick();
        probe();
        check_eq("t2_full_req", instr_req, 0);
        check_eq("t2_full_busy", busy, 1);
        tick();
        probe();
        check_eq("t2_full_req2", instr_req, 0);
        tick();

        // 3: branch to 0x202 with two outstanding
        branch = 1; addr = 32'h202;
        probe();
        check_eq("t3_clear", fifo_clear, 1);
        check_eq("t3_faddr", fifo_addr, 32'h202);
        check_eq("t3_req_full", instr_req, 0);
        tick();
        branch = 0; instr_gnt = 0; instr_rvalid = 1; instr_rdata = 32'hBAD0;
        probe();
        check_eq("t3_clear_off", fifo_clear, 0);
        check_eq("t3_drop0", fifo_valid, 0);
        check_eq("t3_req_still", instr_req, 0);
        tick();
        instr_gnt = 1; instr_rdata = 32'hBAD1;
        probe();
        check_eq("t3_drop1", fifo_valid, 0);
        check_eq("t3_req_tgt", instr_req, 1);
        check_eq("t3_addr_tgt", instr_addr, 32'h200);
        tick();
        req = 0; instr_gnt = 0; instr_rdata = 32'h200D;
        probe();
        check_eq("t3_fwd", fifo_valid, 1);
        check_eq("t3_fwd_data", fifo_rdata, 32'h200D);
        tick();

        // address wrap at the top of memory
        req = 1; branch = 1; addr = 32'hFFFF_FFFE; instr_gnt = 1; instr_rvalid = 0;
        probe();
        check_eq("wrap_addr", instr_addr, 32'hFFFF_FFFC);
        check_eq("wrap_faddr", fifo_addr, 32'hFFFF_FFFE);
        tick();
        branch = 0; instr_gnt = 0; instr_rvalid = 1; instr_rdata = 32'hCC;
        probe();
        check_eq("wrap_next", instr_addr, 32'h0);
        check_eq("wrap_valid", fifo_valid, 1);
        tick();

        // 4: grant stalled at 0x104, branch to 0x400 during the stall
        do_reset();
        req = 1; branch = 1; addr = 32'h100; instr_gnt = 1;
        tick();
        branch = 0; instr_gnt = 0; instr_rvalid = 1; instr_rdata = 32'h1111;
        probe();
        check_eq("t4_addr_w1", instr_addr, 32'h104);
        check_eq("t4_fwd100", fifo_valid, 1);
        tick();
        instr_rvalid = 0; branch = 1; addr = 32'h400;
        probe();
        check_eq("t4_addr_w2", instr_addr, 32'h104);
        check_eq("t4_req_w2", instr_req, 1);
        tick();
        branch = 0; req = 0;
        probe();
        check_eq("t4_addr_w3", instr_addr, 32'h104);
        check_eq("t4_req_w3", instr_req, 1);
        tick();
        req = 1; instr_gnt = 1;
        probe();
        check_eq("t4_addr_gnt", instr_addr, 32'h104);
        tick();
        probe();
        check_eq("t4_addr_tgt", instr_addr, 32'h400);
        tick();
        req = 0; instr_gnt = 0; instr_rvalid = 1; instr_rdata = 32'h1040;
        probe();
        check_eq("t4_drop104", fifo_valid, 0);
        tick();
        instr_rdata = 32'h4000;
        probe();
        check_eq("t4_fwd400", fifo_valid, 1);
        check_eq("t4_data400", fifo_rdata, 32'h4000);
        tick();

        // 5: FIFO full blocks new requests but not a pending one; errors forwarded
        do_reset();
        req = 1; branch = 1; addr = 32'h100;
        tick();
        branch = 0; fifo_ready = 0;
        probe();
        check_eq("t5_hold_req", instr_req, 1);
        check_eq("t5_hold_addr", instr_addr, 32'h100);
        tick();
        instr_gnt = 1;
        probe();
        check_eq("t5_gnt_req", instr_req, 1);
        tick();
        instr_gnt = 0; instr_rvalid = 1; instr_err = 1; instr_rdata = 32'hE;
        probe();
        check_eq("t5_blocked", instr_req, 0);
        check_eq("t5_err_valid", fifo_valid, 1);
        check_eq("t5_err", fifo_err, 1);
        tick();
        instr_rvalid = 0; instr_err = 0; fifo_ready = 1; instr_gnt = 1;
        probe();
        check_eq("t5_resume_req", instr_req, 1);
        check_eq("t5_resume_addr", instr_addr, 32'h104);
        tick();

        // 6: reset with two outstanding
        probe();
        check_eq("t6_addr", instr_addr, 32'h108);
        tick();
        instr_gnt = 0; rst = 1;
        probe();
        check_eq("t6_busy_pre", busy, 1);
        tick();
        instr_rvalid = 1; instr_rdata = 32'hDEAD;
        probe();
        check_eq("t6_busy_post", busy, 0);
        check_eq("t6_late0", fifo_valid, 0);
        tick();
        probe();
        check_eq("t6_late1", fifo_valid, 0);
        tick();
        rst = 0; instr_rvalid = 0; req = 0;
        probe();
        check_eq("t6_busy_rel", busy, 0);
        check_eq("t6_req_rel", instr_req, 0);
        tick();
        req = 1;
        probe();
        check_eq("t6_fetch0", instr_addr, 32'h0);
        check_eq("t6_req_on", instr_req, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
